ex_mem_fwd_stage: RTL and testbench

Parametrised EX/MEM pipeline stage for the pipelined CPU. It combines the EX/MEM pipeline register and the forwarding unit for NUM_SRC source operands, and adds three functions the single-cycle-memory version lacked: a valid bit, a flush, and a load-use bubble. It also implements a req/ack data-memory handshake with a wait-timeout FSM, so the pipeline freezes on slow memory.

---
 rtl/ex_mem_fwd_stage_if.sv | 53 +++++
 rtl/ex_mem_fwd_stage.sv | 127 ++++++++++++
 tb/tb_ex_mem_fwd_stage.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/ex_mem_fwd_stage_if.sv
// EX/MEM stage bundle: EX-side inputs, MEM/WB forwarding inputs, memory handshake and
// the registered EX/MEM outputs with hazard/forwarding controls.
interface ex_mem_fwd_stage_if #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned REG_AW  = 5,
  parameter int unsigned NUM_SRC = 2
);
  logic                      ex_valid_i;
  logic                      ex_mem_read_i;
  logic                      ex_mem_write_i;
  logic                      ex_mem_to_reg_i;
  logic                      ex_reg_write_i;
  logic [DATA_W-1:0]         ex_alu_i;
  logic [DATA_W-1:0]         ex_wdata_i;
  logic [REG_AW-1:0]         ex_rd_i;
  logic                      flush_i;
  logic [NUM_SRC*REG_AW-1:0] src_i;
  logic                      wb_reg_write_i;
  logic [REG_AW-1:0]         wb_rd_i;
  logic                      mem_ack_i;

  logic                      em_valid_o;
  logic                      em_mem_read_o;
  logic                      em_mem_write_o;
  logic                      em_mem_to_reg_o;
  logic                      em_reg_write_o;
  logic [DATA_W-1:0]         em_alu_o;
  logic [DATA_W-1:0]         em_wdata_o;
  logic [REG_AW-1:0]         em_rd_o;
  logic                      mem_req_o;
  logic [NUM_SRC*2-1:0]      fwd_sel_o;
  logic                      mem_stall_o;
  logic                      lu_stall_o;
  logic                      mem_err_o;

  modport master (
    output ex_valid_i, ex_mem_read_i, ex_mem_write_i, ex_mem_to_reg_i, ex_reg_write_i,
           ex_alu_i, ex_wdata_i, ex_rd_i, flush_i, src_i, wb_reg_write_i, wb_rd_i,
           mem_ack_i,
    input  em_valid_o, em_mem_read_o, em_mem_write_o, em_mem_to_reg_o, em_reg_write_o,
           em_alu_o, em_wdata_o, em_rd_o, mem_req_o, fwd_sel_o, mem_stall_o, lu_stall_o,
           mem_err_o
  );

  modport slave (
    input  ex_valid_i, ex_mem_read_i, ex_mem_write_i, ex_mem_to_reg_i, ex_reg_write_i,
           ex_alu_i, ex_wdata_i, ex_rd_i, flush_i, src_i, wb_reg_write_i, wb_rd_i,
           mem_ack_i,
    output em_valid_o, em_mem_read_o, em_mem_write_o, em_mem_to_reg_o, em_reg_write_o,
           em_alu_o, em_wdata_o, em_rd_o, mem_req_o, fwd_sel_o, mem_stall_o, lu_stall_o,
           mem_err_o
  );
endinterface

// File: rtl/ex_mem_fwd_stage.sv
// EX/MEM pipeline register with operand forwarding, load-use bubble insertion and a
// req/ack data-memory handshake guarded by a wait-timeout FSM.
module ex_mem_fwd_stage #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned REG_AW   = 5,
  parameter int unsigned NUM_SRC  = 2,
  parameter int unsigned MAX_WAIT = 15
) (
  input logic            clk_i,
  input logic            rst_i,
  ex_mem_fwd_stage_if.slave bus
);
  localparam int unsigned CntW = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {StIdle, StWait, StErr} state_e;

  state_e            state_q;
  logic [CntW-1:0]   cnt_q;

  logic              em_valid_q;
  logic              em_mem_read_q;
  logic              em_mem_write_q;
  logic              em_mem_to_reg_q;
  logic              em_reg_write_q;
  logic [DATA_W-1:0] em_alu_q;
  logic [DATA_W-1:0] em_wdata_q;
  logic [REG_AW-1:0] em_rd_q;

  logic                 pend;
  logic                 mem_req;
  logic                 mem_stall;
  logic                 lu_stall;
  logic                 bubble;
  logic [NUM_SRC-1:0]   lu_hit;
  logic [NUM_SRC*2-1:0] fwd_sel;
  logic [REG_AW-1:0]    src;

  assign pend      = em_valid_q & (em_mem_read_q | em_mem_write_q);
  assign mem_req   = pend & (state_q != StErr);
  assign mem_stall = (mem_req & ~bus.mem_ack_i) | (state_q == StErr);

  always_comb begin
    fwd_sel = '0;
    lu_hit  = '0;
    src     = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      src = bus.src_i[k*REG_AW +: REG_AW];
      if (src != '0) begin
        if (em_valid_q && em_reg_write_q && !em_mem_read_q && (em_rd_q == src)) begin
          fwd_sel[k*2 +: 2] = 2'b10;
        end else if (bus.wb_reg_write_i && (bus.wb_rd_i == src)) begin
          fwd_sel[k*2 +: 2] = 2'b01;
        end
        lu_hit[k] = em_valid_q & em_mem_read_q & em_reg_write_q & (em_rd_q == src);
      end
    end
  end

  // A memory stall freezes the consumer anyway, so it suppresses the load-use bubble.
  assign lu_stall = (|lu_hit) & ~mem_stall & bus.ex_valid_i;
  assign bubble   = bus.flush_i | lu_stall | ~bus.ex_valid_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      em_valid_q      <= 1'b0;
      em_mem_read_q   <= 1'b0;
      em_mem_write_q  <= 1'b0;
      em_mem_to_reg_q <= 1'b0;
      em_reg_write_q  <= 1'b0;
      em_alu_q        <= '0;
      em_wdata_q      <= '0;
      em_rd_q         <= '0;
    end else if (!mem_stall) begin
      em_valid_q      <= ~bubble;
      em_mem_read_q   <= ~bubble & bus.ex_mem_read_i;
      em_mem_write_q  <= ~bubble & bus.ex_mem_write_i;
      em_mem_to_reg_q <= ~bubble & bus.ex_mem_to_reg_i;
      em_reg_write_q  <= ~bubble & bus.ex_reg_write_i;
      em_alu_q        <= bus.ex_alu_i;
      em_wdata_q      <= bus.ex_wdata_i;
      em_rd_q         <= bus.ex_rd_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          // Same-cycle ack completes with zero wait and never leaves idle.
          if (mem_req && !bus.mem_ack_i) begin
            state_q <= StWait;
            cnt_q   <= CntW'(1);
          end
        end
        StWait: begin
          if (bus.mem_ack_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
          end else if (cnt_q == CntW'(MAX_WAIT)) begin
            state_q <= StErr;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StErr:   state_q <= StErr;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.em_valid_o      = em_valid_q;
  assign bus.em_mem_read_o   = em_mem_read_q;
  assign bus.em_mem_write_o  = em_mem_write_q;
  assign bus.em_mem_to_reg_o = em_mem_to_reg_q;
  assign bus.em_reg_write_o  = em_reg_write_q;
  assign bus.em_alu_o        = em_alu_q;
  assign bus.em_wdata_o      = em_wdata_q;
  assign bus.em_rd_o         = em_rd_q;
  assign bus.mem_req_o       = mem_req;
  assign bus.fwd_sel_o       = fwd_sel;
  assign bus.mem_stall_o     = mem_stall;
  assign bus.lu_stall_o      = lu_stall;
  assign bus.mem_err_o       = (state_q == StErr);
endmodule

// File: tb/tb_ex_mem_fwd_stage.sv
// Directed bench for ex_mem_fwd_stage: a vector table for forwarding/load-use/bubbles and
// hand-written sequences for memory stalls, flush, reset mid-wait and timeout.
module tb_ex_mem_fwd_stage;
  logic clk;
  logic rst_n;
  int   n_cmp = 0;
  int   n_bad = 0;

  ex_mem_fwd_stage_if #(.DATA_W(32), .REG_AW(5), .NUM_SRC(2)) bus ();

  ex_mem_fwd_stage #(
    .DATA_W  (32),
    .REG_AW  (5),
    .NUM_SRC (2),
    .MAX_WAIT(15)
  ) dut (
    .clk_i(clk),
    .rst_i(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        flush;
    logic        valid;
    logic        rd_en;
    logic        wr_en;
    logic        m2r;
    logic        rw;
    logic [31:0] alu;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic [4:0]  src0;
    logic [4:0]  src1;
    logic        wb_rw;
    logic [4:0]  wb_rd;
    logic        ack;
  } vin_t;

  typedef struct packed {
    vin_t        in;
    logic [3:0]  fwd;
    logic        lu;
    logic        stall;
    logic        req;
    logic        em_valid;
    logic [4:0]  em_rd;
    logic [31:0] em_alu;
    logic [31:0] em_wdata;
  } vec_t;

  function automatic vin_t mk_in(input logic flush, input logic valid, input logic rd_en,
                                 input logic wr_en, input logic m2r, input logic rw,
                                 input logic [31:0] alu, input logic [31:0] wdata,
                                 input logic [4:0] rd, input logic [4:0] src0,
                                 input logic [4:0] src1, input logic wb_rw,
                                 input logic [4:0] wb_rd, input logic ack);
    vin_t v;
    v.flush = flush; v.valid = valid; v.rd_en = rd_en; v.wr_en = wr_en; v.m2r = m2r;
    v.rw = rw; v.alu = alu; v.wdata = wdata; v.rd = rd; v.src0 = src0; v.src1 = src1;
    v.wb_rw = wb_rw; v.wb_rd = wb_rd; v.ack = ack;
    return v;
  endfunction

  task automatic drive(input vin_t v);
    bus.flush_i         = v.flush;
    bus.ex_valid_i      = v.valid;
    bus.ex_mem_read_i   = v.rd_en;
    bus.ex_mem_write_i  = v.wr_en;
    bus.ex_mem_to_reg_i = v.m2r;
    bus.ex_reg_write_i  = v.rw;
    bus.ex_alu_i        = v.alu;
    bus.ex_wdata_i      = v.wdata;
    bus.ex_rd_i         = v.rd;
    bus.src_i           = {v.src1, v.src0};
    bus.wb_reg_write_i  = v.wb_rw;
    bus.wb_rd_i         = v.wb_rd;
    bus.mem_ack_i       = v.ack;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[4];

  initial begin
    vecs[0] = '{in: mk_in(0, 1, 0, 0, 0, 1, 100, 0, 5, 0, 0, 0, 0, 0),
                fwd: 4'b0000, lu: 0, stall: 0, req: 0,
                em_valid: 1, em_rd: 5, em_alu: 100, em_wdata: 0};
    // ALU rd=5 in EX/MEM beats MEM/WB rd=5 for src0.
    vecs[1] = '{in: mk_in(0, 1, 1, 0, 1, 1, 200, 0, 22, 5, 0, 1, 5, 0),
                fwd: 4'b0010, lu: 0, stall: 0, req: 0,
                em_valid: 1, em_rd: 22, em_alu: 200, em_wdata: 0};
    // Load rd=22 acked same cycle; src1=22 -> load-use bubble, select from MEM/WB.
    vecs[2] = '{in: mk_in(0, 1, 0, 0, 0, 1, 300, 0, 7, 0, 22, 1, 22, 1),
                fwd: 4'b0100, lu: 1, stall: 0, req: 1,
                em_valid: 0, em_rd: 7, em_alu: 300, em_wdata: 0};
    vecs[3] = '{in: mk_in(0, 1, 0, 1, 0, 0, 0, 155, 0, 0, 0, 0, 0, 0),
                fwd: 4'b0000, lu: 0, stall: 0, req: 0,
                em_valid: 1, em_rd: 0, em_alu: 0, em_wdata: 155};

    rst_n = 1'b0;
    drive(mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #3;
    chk("rst_em_valid", 64'(bus.em_valid_o), 64'd0);
    chk("rst_em_alu", 64'(bus.em_alu_o), 64'd0);
    chk("rst_req", 64'(bus.mem_req_o), 64'd0);
    chk("rst_stall", 64'(bus.mem_stall_o), 64'd0);
    chk("rst_err", 64'(bus.mem_err_o), 64'd0);
    chk("rst_fwd", 64'(bus.fwd_sel_o), 64'd0);
    #9 rst_n = 1'b1;
    tick();

    for (int i = 0; i < 4; i++) begin
      drive(vecs[i].in);
      #1;
      chk($sformatf("v%0d_fwd", i), 64'(bus.fwd_sel_o), 64'(vecs[i].fwd));
      chk($sformatf("v%0d_lu", i), 64'(bus.lu_stall_o), 64'(vecs[i].lu));
      chk($sformatf("v%0d_stall", i), 64'(bus.mem_stall_o), 64'(vecs[i].stall));
      chk($sformatf("v%0d_req", i), 64'(bus.mem_req_o), 64'(vecs[i].req));
      tick();
      chk($sformatf("v%0d_em_valid", i), 64'(bus.em_valid_o), 64'(vecs[i].em_valid));
      chk($sformatf("v%0d_em_rd", i), 64'(bus.em_rd_o), 64'(vecs[i].em_rd));
      chk($sformatf("v%0d_em_alu", i), 64'(bus.em_alu_o), 64'(vecs[i].em_alu));
      chk($sformatf("v%0d_em_wdata", i), 64'(bus.em_wdata_o), 64'(vecs[i].em_wdata));
    end

    // Store (alu 0, wdata 155) with ack four cycles late; flush pulse mid-stall.
    for (int c = 0; c < 4; c++) begin
      drive(mk_in((c == 1), 1, 0, 0, 0, 1, 999, 1, 9, 0, 0, 0, 0, 0));
      #1;
      chk($sformatf("st%0d_req", c), 64'(bus.mem_req_o), 64'd1);
      chk($sformatf("st%0d_stall", c), 64'(bus.mem_stall_o), 64'd1);
      tick();
      chk($sformatf("st%0d_em_valid", c), 64'(bus.em_valid_o), 64'd1);
      chk($sformatf("st%0d_em_write", c), 64'(bus.em_mem_write_o), 64'd1);
      chk($sformatf("st%0d_em_wdata", c), 64'(bus.em_wdata_o), 64'd155);
    end
    drive(mk_in(0, 1, 0, 0, 0, 1, 999, 1, 9, 0, 0, 0, 0, 1));
    #1;
    chk("st_ack_req", 64'(bus.mem_req_o), 64'd1);
    chk("st_ack_stall", 64'(bus.mem_stall_o), 64'd0);
    tick();
    chk("st_next_alu", 64'(bus.em_alu_o), 64'd999);
    chk("st_next_valid", 64'(bus.em_valid_o), 64'd1);
    bus.mem_ack_i = 1'b0;
    #1;
    chk("st_req_drop", 64'(bus.mem_req_o), 64'd0);
    chk("st_stall_drop", 64'(bus.mem_stall_o), 64'd0);

    // Flush of a valid load with no stall.
    drive(mk_in(1, 1, 1, 0, 1, 1, 50, 0, 3, 0, 0, 0, 0, 0));
    #1;
    chk("fl_stall", 64'(bus.mem_stall_o), 64'd0);
    tick();
    bus.flush_i = 1'b0;
    bus.src_i   = {5'd0, 5'd3};
    #1;
    chk("fl_em_valid", 64'(bus.em_valid_o), 64'd0);
    chk("fl_em_read", 64'(bus.em_mem_read_o), 64'd0);
    chk("fl_req", 64'(bus.mem_req_o), 64'd0);
    chk("fl_fwd", 64'(bus.fwd_sel_o), 64'd0);

    // Reset asserted while waiting with counter = 3.
    drive(mk_in(0, 1, 0, 1, 0, 0, 4, 77, 0, 0, 0, 0, 0, 0));
    tick();
    chk("rw_req", 64'(bus.mem_req_o), 64'd1);
    chk("rw_stall", 64'(bus.mem_stall_o), 64'd1);
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("rw_em_valid", 64'(bus.em_valid_o), 64'd0);
    chk("rw_em_wdata", 64'(bus.em_wdata_o), 64'd0);
    chk("rw_req0", 64'(bus.mem_req_o), 64'd0);
    chk("rw_stall0", 64'(bus.mem_stall_o), 64'd0);
    chk("rw_err0", 64'(bus.mem_err_o), 64'd0);
    #2 rst_n = 1'b1;
    tick();
    chk("rw_reload_req", 64'(bus.mem_req_o), 64'd1);
    chk("rw_reload_wdata", 64'(bus.em_wdata_o), 64'd77);
    drive(mk_in(0, 1, 1, 0, 1, 1, 60, 0, 12, 0, 0, 0, 0, 1));
    #1;
    chk("rw_ack_stall", 64'(bus.mem_stall_o), 64'd0);
    tick();

    // Load rd=12 never acked: stall dominates load-use, then timeout to the error state.
    drive(mk_in(0, 1, 0, 0, 0, 1, 70, 0, 8, 12, 0, 0, 0, 0));
    #1;
    chk("to_stall", 64'(bus.mem_stall_o), 64'd1);
    chk("to_lu", 64'(bus.lu_stall_o), 64'd0);
    chk("to_fwd", 64'(bus.fwd_sel_o), 64'd0);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("to_err_low%0d", i), 64'(bus.mem_err_o), 64'd0);
      tick();
    end
    chk("to_err", 64'(bus.mem_err_o), 64'd1);
    chk("to_req", 64'(bus.mem_req_o), 64'd0);
    chk("to_stall_err", 64'(bus.mem_stall_o), 64'd1);
    chk("to_em_rd", 64'(bus.em_rd_o), 64'd12);
    bus.mem_ack_i = 1'b1;
    tick();
    tick();
    chk("to_err_sticky", 64'(bus.mem_err_o), 64'd1);
    chk("to_stall_sticky", 64'(bus.mem_stall_o), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("to_rst_err", 64'(bus.mem_err_o), 64'd0);
    chk("to_rst_stall", 64'(bus.mem_stall_o), 64'd0);
    #2 rst_n = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
